// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default sizes for the writeback arbiter
package wb_pkg;
    localparam int NUM_SRC_DEF = 6;
    localparam int NUM_WR_DEF  = 4;
    localparam int PREG_W      = 5;
    localparam int DATA_W      = 16;
    localparam int TAG_W       = 5;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [TAG_W-1:0]  rob_tag_t;

    typedef struct packed {
        logic     wen;
        preg_t    preg;
        data_t    data;
        rob_tag_t tag;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - functional-unit result inputs and regfile/ROB write outputs
interface wb_arbiter_if import wb_pkg::*; #(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int NUM_WR  = NUM_WR_DEF
) ();
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC-1:0]        src_wen;
    logic [NUM_SRC*PREG_W-1:0] src_preg;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_WR-1:0]         reg_wr_en;
    logic [NUM_WR*PREG_W-1:0]  reg_wr_addr;
    logic [NUM_WR*DATA_W-1:0]  reg_wr_data;
    logic [NUM_WR-1:0]         cmp_valid;
    logic [NUM_WR*TAG_W-1:0]   cmp_tag;

    modport master (
        output src_valid, src_wen, src_preg, src_data, src_tag,
        input  src_ready, reg_wr_en, reg_wr_addr, reg_wr_data, cmp_valid, cmp_tag
    );
    modport slave (
        input  src_valid, src_wen, src_preg, src_data, src_tag,
        output src_ready, reg_wr_en, reg_wr_addr, reg_wr_data, cmp_valid, cmp_tag
    );
endinterface

// File: rtl/wb_rr_select.sv
// rtl/wb_rr_select.sv - rotating picker: k-th held entry from rr_ptr goes to write port k
module wb_rr_select import wb_pkg::*; #(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int NUM_WR  = NUM_WR_DEF
) (
    input  logic [NUM_SRC-1:0]              hv_i,
    input  logic [$clog2(NUM_SRC)-1:0]      rr_ptr_i,
    output logic [NUM_WR-1:0][NUM_SRC-1:0]  sel_o,
    output logic [NUM_WR-1:0]               port_vld_o,
    output logic [$clog2(NUM_SRC)-1:0]      rr_ptr_nxt_o
);
    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int KW    = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    always_comb begin
        int cnt;
        int idx;
        int nxt;
        sel_o      = '0;
        port_vld_o = '0;
        cnt        = 0;
        idx        = 0;
        nxt        = int'(rr_ptr_i);
        for (int j = 0; j < NUM_SRC; j++) begin
            idx = int'(rr_ptr_i) + j;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (hv_i[PTR_W'(idx)] && cnt < NUM_WR) begin
                sel_o[KW'(cnt)][PTR_W'(idx)] = 1'b1;
                port_vld_o[KW'(cnt)]         = 1'b1;
                nxt = (idx == NUM_SRC - 1) ? 0 : idx + 1;
                cnt = cnt + 1;
            end
        end
        rr_ptr_nxt_o = PTR_W'(nxt);
    end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter into the regfile write ports.
// WB_PERF_EN adds perf_stall_cnt / perf_wr_cnt counters.
module wb_arbiter import wb_pkg::*; #(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int NUM_WR  = NUM_WR_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
`ifdef WB_PERF_EN
    ,
    output logic [31:0]  perf_stall_cnt,
    output logic [31:0]  perf_wr_cnt
`endif
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]             hv_q, hv_d, grant, ready, accept;
    wb_req_t                        req_q [NUM_SRC];
    wb_req_t                        req_d [NUM_SRC];
    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_WR-1:0][NUM_SRC-1:0] sel;
    logic [NUM_WR-1:0]              port_vld;
    logic [NUM_WR-1:0]              wr_en_q, wr_en_d, cmp_vld_q, cmp_vld_d;
    wb_req_t                        out_q [NUM_WR];
    wb_req_t                        out_d [NUM_WR];
    logic                           dup_preg;

    wb_rr_select #(.NUM_SRC(NUM_SRC), .NUM_WR(NUM_WR)) u_sel (
        .hv_i         (hv_q),
        .rr_ptr_i     (rr_ptr_q),
        .sel_o        (sel),
        .port_vld_o   (port_vld),
        .rr_ptr_nxt_o (rr_ptr_d)
    );

    // Ready depends only on held state and grant, never on src_valid.
    always_comb begin
        grant = '0;
        for (int k = 0; k < NUM_WR; k++) grant = grant | sel[k];
    end

    assign ready         = ~hv_q | grant;
    assign accept        = bus.src_valid & ready;
    assign bus.src_ready = ready;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            hv_d[i]  = accept[i] | (hv_q[i] & ~grant[i]);
            req_d[i] = req_q[i];
            if (accept[i]) begin
                req_d[i].wen  = bus.src_wen[i];
                req_d[i].preg = bus.src_preg[i*PREG_W +: PREG_W];
                req_d[i].data = bus.src_data[i*DATA_W +: DATA_W];
                req_d[i].tag  = bus.src_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            out_d[k] = '0;
            for (int i = 0; i < NUM_SRC; i++)
                if (sel[k][i]) out_d[k] = req_q[i];
            wr_en_d[k] = port_vld[k] & out_d[k].wen;
        end
        cmp_vld_d = port_vld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q      <= '0;
            rr_ptr_q  <= '0;
            wr_en_q   <= '0;
            cmp_vld_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) req_q[i] <= '0;
            for (int k = 0; k < NUM_WR; k++)  out_q[k] <= '0;
        end else begin
            hv_q      <= hv_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            cmp_vld_q <= cmp_vld_d;
            for (int i = 0; i < NUM_SRC; i++) req_q[i] <= req_d[i];
            for (int k = 0; k < NUM_WR; k++)  out_q[k] <= out_d[k];
        end
    end

    always_comb begin
        bus.reg_wr_addr = '0;
        bus.reg_wr_data = '0;
        bus.cmp_tag     = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            bus.reg_wr_addr[k*PREG_W +: PREG_W] = out_q[k].preg;
            bus.reg_wr_data[k*DATA_W +: DATA_W] = out_q[k].data;
            bus.cmp_tag[k*TAG_W +: TAG_W]       = out_q[k].tag;
        end
    end

    assign bus.reg_wr_en = wr_en_q;
    assign bus.cmp_valid = cmp_vld_q;

    // The renamer never issues the same preg twice in flight; flag it if it does.
    always_comb begin
        dup_preg = 1'b0;
        for (int k = 0; k < NUM_WR; k++)
            for (int l = k + 1; l < NUM_WR; l++)
                if (wr_en_q[k] && wr_en_q[l] && out_q[k].preg == out_q[l].preg)
                    dup_preg = 1'b1;
    end

    a_no_dup_preg: assert property (@(posedge clk) disable iff (!rst_n) !dup_preg);

`ifdef WB_PERF_EN
    logic [31:0] stall_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + 32'(|(hv_q & ~grant));
            wr_cnt_q    <= wr_cnt_q + 32'($countones(wr_en_q));
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_wr_cnt    = wr_cnt_q;
`endif
endmodule
